rvv_backend_rob_mp: RTL and testbench

- Parametrised multi-port reorder buffer for the RVV backend.
- Accepts up to NUM_DP in-order uops per cycle from Dispatch.
- Collects out-of-order results from NUM_WB processing-unit writeback ports.
- Retires up to NUM_RT completed uops per cycle, in order, to the retire unit.
- Adds capabilities the current ROB lacks: wrap-bit pointers, an occupancy count, prefix-enforced handshakes, trap-gated dispatch and a full flush with pointer reset.

---
 rtl/rvv_rob_pkg.sv | 30 +++
 rtl/rvv_rob_rotate.sv | 19 +
 rtl/rvv_backend_rob_mp.sv | 223 ++++++++++++++++++++++
 tb/tb_rvv_backend_rob_mp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_rob_pkg.sv
// Shared types, default sizing and helpers for the RVV backend multi-port reorder buffer.
package rvv_rob_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_NUM_DP = 2;
    localparam int ROB_NUM_RT = 4;
    localparam int ROB_NUM_WB = 9;
    localparam int ROB_INFO_W = 64;
    localparam int ROB_DATA_W = 128;

    typedef struct packed {
        logic                  wvalid;
        logic                  vsat;
        logic [ROB_DATA_W-1:0] data;
    } RES_ENTRY_t;

    // Number of consecutive ones starting at bit 0.
    function automatic logic [5:0] prefix_len(input logic [31:0] v);
        logic [5:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            run = run & v[i];
            n   = n + 6'(run);
        end
        return n;
    endfunction

endpackage

// File: rtl/rvv_rob_rotate.sv
// Barrel rotator: output slot j carries input slot (shift + j) mod N, for the first NOUT slots.
module rvv_rob_rotate #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int NOUT  = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*W-1:0]    din,
    input  logic [SEL_W-1:0]  shift,
    output logic [NOUT*W-1:0] dout
);

    for (genvar j = 0; j < NOUT; j++) begin : g_slot
        logic [SEL_W-1:0] idx;
        assign idx              = shift + SEL_W'(j);
        assign dout[j*W +: W]   = din[int'(idx)*W +: W];
    end

endmodule

// File: rtl/rvv_backend_rob_mp.sv
// Multi-port reorder buffer: in-order dispatch, out-of-order writeback, in-order retire with trap flush.
// Define ROB_FWD_EN to add the oldest-first fwd_view forwarding port.
module rvv_backend_rob_mp
    import rvv_rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int NUM_DP = ROB_NUM_DP,
    parameter int NUM_RT = ROB_NUM_RT,
    parameter int NUM_WB = ROB_NUM_WB,
    parameter int INFO_W = ROB_INFO_W,
    parameter int DATA_W = ROB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_DP-1:0]        dp_valid,
    input  logic [NUM_DP*INFO_W-1:0] dp_info,
    output logic [NUM_DP-1:0]        dp_ready,
    output logic [PTR_W-1:0]         dp_index,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PTR_W-1:0]  wb_entry,
    input  logic [NUM_WB-1:0]        wb_wvalid,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_WB-1:0]        wb_vsat,
    output logic [NUM_RT-1:0]        rt_valid,
    output logic [NUM_RT*INFO_W-1:0] rt_info,
    output logic [NUM_RT-1:0]        rt_wvalid,
    output logic [NUM_RT*DATA_W-1:0] rt_data,
    output logic [NUM_RT-1:0]        rt_vsat,
    output logic [NUM_RT-1:0]        rt_trap,
    input  logic [NUM_RT-1:0]        rt_ready,
    input  logic                     trap_valid,
    input  logic [PTR_W-1:0]         trap_entry,
    output logic                     trap_ready,
    output logic [PTR_W:0]           occupancy
`ifdef ROB_FWD_EN
    ,
    output logic [DEPTH*(2+INFO_W+DATA_W)-1:0] fwd_view
`endif
);

    localparam int SLOT_W = 5 + INFO_W + DATA_W;
    localparam int VS_B   = DATA_W + INFO_W;
    localparam int WV_B   = VS_B + 1;
    localparam int T_B    = VS_B + 2;
    localparam int D_B    = VS_B + 3;
    localparam int V_B    = VS_B + 4;
`ifdef ROB_FWD_EN
    localparam int VIEW_N = DEPTH;
`else
    localparam int VIEW_N = NUM_RT;
`endif

    logic [PTR_W:0]        wptr, rptr, free_cnt, push_cnt, pop_cnt;
    logic [DEPTH-1:0]      valid_q, done_q, trap_q, wvalid_q, vsat_q;
    logic [DEPTH-1:0]      valid_nxt, done_nxt, trap_nxt;
    logic [INFO_W-1:0]     info_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [NUM_DP-1:0]     push_mask;
    logic [NUM_RT-1:0]     pop_mask;
    logic [PTR_W-1:0]      push_e [NUM_DP];
    logic [PTR_W-1:0]      pop_e  [NUM_RT];
    logic [PTR_W-1:0]      wb_e   [NUM_WB];
    logic                  trap_pending, flush;
    logic [DEPTH*SLOT_W-1:0]  slots;
    logic [VIEW_N*SLOT_W-1:0] view;

    assign occupancy    = wptr - rptr;
    assign free_cnt     = (PTR_W+1)'(DEPTH) - occupancy;
    assign dp_index     = wptr[PTR_W-1:0];
    assign trap_ready   = 1'b1;
    assign trap_pending = |(rt_valid & rt_trap);

    // Entry state presented oldest-first through the rotator
    for (genvar e = 0; e < DEPTH; e++) begin : g_pack
        assign slots[e*SLOT_W +: SLOT_W] = {valid_q[e], done_q[e], trap_q[e], wvalid_q[e],
                                            vsat_q[e], info_q[e], data_q[e]};
    end

    rvv_rob_rotate #(
        .N    (DEPTH),
        .W    (SLOT_W),
        .NOUT (VIEW_N)
    ) u_rotate (
        .din   (slots),
        .shift (rptr[PTR_W-1:0]),
        .dout  (view)
    );

    // Retire slots: stop after the first not-done entry, and after a trapping one
    always_comb begin
        logic              run;
        logic [SLOT_W-1:0] slot;
        run       = 1'b1;
        rt_valid  = '0;
        rt_trap   = '0;
        rt_wvalid = '0;
        rt_vsat   = '0;
        rt_info   = '0;
        rt_data   = '0;
        for (int i = 0; i < NUM_RT; i++) begin
            slot         = view[i*SLOT_W +: SLOT_W];
            run          = run & slot[V_B] & slot[D_B];
            rt_valid[i]  = run;
            rt_trap[i]   = run & slot[T_B];
            rt_wvalid[i] = run & slot[WV_B];
            rt_vsat[i]   = run & slot[VS_B];
            rt_info[i*INFO_W +: INFO_W] = run ? slot[DATA_W +: INFO_W] : '0;
            rt_data[i*DATA_W +: DATA_W] = run ? slot[DATA_W-1:0] : '0;
            run          = run & ~slot[T_B];
        end
    end

`ifdef ROB_FWD_EN
    always_comb begin
        logic [SLOT_W-1:0] slot;
        fwd_view = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot = view[j*SLOT_W +: SLOT_W];
            fwd_view[j*(2+INFO_W+DATA_W) +: (2+INFO_W+DATA_W)] =
                {slot[V_B], slot[D_B] & slot[WV_B], slot[DATA_W +: INFO_W], slot[DATA_W-1:0]};
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_DP; i++) begin
            dp_ready[i] = rst_n && !trap_pending && (int'(free_cnt) > i);
        end
    end

    always_comb begin
        push_cnt = (PTR_W+1)'(prefix_len(32'(dp_valid & dp_ready)));
        pop_cnt  = (PTR_W+1)'(prefix_len(32'(rt_valid & rt_ready)));
        for (int i = 0; i < NUM_DP; i++) begin
            push_mask[i] = (PTR_W+1)'(i) < push_cnt;
            push_e[i]    = wptr[PTR_W-1:0] + PTR_W'(i);
        end
        for (int i = 0; i < NUM_RT; i++) begin
            pop_mask[i] = (PTR_W+1)'(i) < pop_cnt;
            pop_e[i]    = rptr[PTR_W-1:0] + PTR_W'(i);
        end
        for (int p = 0; p < NUM_WB; p++) begin
            wb_e[p] = wb_entry[p*PTR_W +: PTR_W];
        end
        flush = |(pop_mask & rt_trap);
    end

    always_comb begin
        valid_nxt = valid_q;
        done_nxt  = done_q;
        trap_nxt  = trap_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) done_nxt[wb_e[p]] = 1'b1;
        end
        if (trap_valid && valid_q[trap_entry]) trap_nxt[trap_entry] = 1'b1;
        for (int i = 0; i < NUM_RT; i++) begin
            if (pop_mask[i]) begin
                valid_nxt[pop_e[i]] = 1'b0;
                done_nxt[pop_e[i]]  = 1'b0;
                trap_nxt[pop_e[i]]  = 1'b0;
            end
        end
        for (int i = 0; i < NUM_DP; i++) begin
            if (push_mask[i]) begin
                valid_nxt[push_e[i]] = 1'b1;
                done_nxt[push_e[i]]  = 1'b0;
                trap_nxt[push_e[i]]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            valid_q <= '0;
            done_q  <= '0;
            trap_q  <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            valid_q <= '0;
            done_q  <= '0;
            trap_q  <= '0;
        end else begin
            wptr    <= wptr + push_cnt;
            rptr    <= rptr + pop_cnt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            trap_q  <= trap_nxt;
        end
    end

    // Payload storage is qualified by valid/done, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DP; i++) begin
            if (push_mask[i]) info_q[push_e[i]] <= dp_info[i*INFO_W +: INFO_W];
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && !flush) begin
                data_q[wb_e[p]]   <= wb_data[p*DATA_W +: DATA_W];
                wvalid_q[wb_e[p]] <= wb_wvalid[p];
                vsat_q[wb_e[p]]   <= wb_vsat[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p]) begin
                    assert (valid_q[wb_e[p]]);
                    assert (!done_q[wb_e[p]]);
                    for (int q = p + 1; q < NUM_WB; q++) begin
                        assert (!(wb_valid[q] && wb_e[q] == wb_e[p]));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rvv_backend_rob_mp.sv
// Scoreboard bench for rvv_backend_rob_mp: directed stimulus queues expected retirements, a monitor checks them.
module tb_rvv_backend_rob_mp;

    localparam int DEPTH  = 8;
    localparam int NUM_DP = 2;
    localparam int NUM_RT = 4;
    localparam int NUM_WB = 9;
    localparam int INFO_W = 64;
    localparam int DATA_W = 128;
    localparam int PTR_W  = 3;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_DP-1:0]        dp_valid;
    logic [NUM_DP*INFO_W-1:0] dp_info;
    logic [NUM_DP-1:0]        dp_ready;
    logic [PTR_W-1:0]         dp_index;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*PTR_W-1:0]  wb_entry;
    logic [NUM_WB-1:0]        wb_wvalid;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [NUM_WB-1:0]        wb_vsat;
    logic [NUM_RT-1:0]        rt_valid;
    logic [NUM_RT*INFO_W-1:0] rt_info;
    logic [NUM_RT-1:0]        rt_wvalid;
    logic [NUM_RT*DATA_W-1:0] rt_data;
    logic [NUM_RT-1:0]        rt_vsat;
    logic [NUM_RT-1:0]        rt_trap;
    logic [NUM_RT-1:0]        rt_ready;
    logic                     trap_valid;
    logic [PTR_W-1:0]         trap_entry;
    logic                     trap_ready;
    logic [PTR_W:0]           occupancy;
`ifdef ROB_FWD_EN
    logic [DEPTH*(2+INFO_W+DATA_W)-1:0] fwd_view;
`endif

    rvv_backend_rob_mp #(
        .DEPTH(DEPTH), .NUM_DP(NUM_DP), .NUM_RT(NUM_RT),
        .NUM_WB(NUM_WB), .INFO_W(INFO_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dp_valid(dp_valid), .dp_info(dp_info), .dp_ready(dp_ready), .dp_index(dp_index),
        .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_wvalid(wb_wvalid),
        .wb_data(wb_data), .wb_vsat(wb_vsat),
        .rt_valid(rt_valid), .rt_info(rt_info), .rt_wvalid(rt_wvalid), .rt_data(rt_data),
        .rt_vsat(rt_vsat), .rt_trap(rt_trap), .rt_ready(rt_ready),
        .trap_valid(trap_valid), .trap_entry(trap_entry), .trap_ready(trap_ready),
        .occupancy(occupancy)
`ifdef ROB_FWD_EN
        , .fwd_view(fwd_view)
`endif
    );

    typedef struct {
        logic [63:0]  info;
        logic         wv;
        logic [127:0] data;
        logic         vs;
        logic         tr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int p, input int e, input logic wv, input logic [127:0] d,
                          input logic vs);
        wb_valid[p]                   = 1'b1;
        wb_entry[p*PTR_W +: PTR_W]    = PTR_W'(e);
        wb_wvalid[p]                  = wv;
        wb_data[p*DATA_W +: DATA_W]   = d;
        wb_vsat[p]                    = vs;
    endtask

    task automatic clr_wb();
        wb_valid  = '0;
        wb_entry  = '0;
        wb_wvalid = '0;
        wb_data   = '0;
        wb_vsat   = '0;
    endtask

    task automatic expect_rt(input logic [63:0] info, input logic wv, input logic [127:0] d,
                             input logic vs, input logic tr);
        exp_t x;
        x.info = info; x.wv = wv; x.data = d; x.vs = vs; x.tr = tr;
        sb.push_back(x);
    endtask

    // Monitor: every accepted retire slot must match the head of the scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < NUM_RT; i++) begin
            exp_t x;
            if (!(rt_valid[i] && rt_ready[i])) break;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rt_unexpected slot=%0d actual info=%0h required none",
                         i, rt_info[i*INFO_W +: INFO_W]);
            end else begin
                x = sb.pop_front();
                chk("rt_info",   128'(rt_info[i*INFO_W +: INFO_W]), 128'(x.info));
                chk("rt_wvalid", 128'(rt_wvalid[i]), 128'(x.wv));
                chk("rt_data",   rt_data[i*DATA_W +: DATA_W], x.data);
                chk("rt_vsat",   128'(rt_vsat[i]), 128'(x.vs));
                chk("rt_trap",   128'(rt_trap[i]), 128'(x.tr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dp_valid = '0; dp_info = '0; rt_ready = '0;
        trap_valid = 1'b0; trap_entry = '0;
        clr_wb();
        tick(); tick();
        chk("rst_occupancy",  128'(occupancy), 128'(0));
        chk("rst_rt_valid",   128'(rt_valid), 128'(0));
        chk("rst_trap_ready", 128'(trap_ready), 128'(1));
        chk("rst_dp_index",   128'(dp_index), 128'(0));
        chk("rst_dp_ready",   128'(dp_ready), 128'(0));
        rst_n = 1'b1; rt_ready = 4'b1111;

        // Two pushes, out-of-order writeback, then both retire together
        dp_valid = 2'b11; dp_info = {64'hB, 64'hA};
        #1 chk("t1_dp_ready", 128'(dp_ready), 128'(2'b11));
        tick();
        dp_valid = '0;
        set_wb(3, 1, 1'b0, 128'h22, 1'b1);
        #1 chk("t1_occ2", 128'(occupancy), 128'(2));
        chk("t1_rt_none_a", 128'(rt_valid), 128'(0));
        chk("t1_dp_index", 128'(dp_index), 128'(2));
        tick();
        clr_wb();
        set_wb(0, 0, 1'b1, 128'h11, 1'b0);
        expect_rt(64'hA, 1'b1, 128'h11, 1'b0, 1'b0);
        expect_rt(64'hB, 1'b0, 128'h22, 1'b1, 1'b0);
        #1 chk("t1_rt_none_b", 128'(rt_valid), 128'(0));
        tick();
        clr_wb();
        #1 chk("t1_rt_valid", 128'(rt_valid), 128'(4'b0011));
        chk("t1_rt_info", rt_info[127:0], {64'hB, 64'hA});
        chk("t1_occ_before", 128'(occupancy), 128'(2));
        tick();
        chk("t1_occ_after", 128'(occupancy), 128'(0));
        chk("t1_rt_empty", 128'(rt_valid), 128'(0));

        // Trap on the second of four done entries: two retire, then flush
        rt_ready = '0;
        dp_valid = 2'b11; dp_info = {64'h31, 64'h30};
        tick();
        dp_info = {64'h33, 64'h32};
        tick();
        dp_valid = '0;
        for (int k = 0; k < 4; k++) set_wb(k, 2 + k, 1'b1, 128'h300 + 128'(k), 1'b0);
        trap_valid = 1'b1; trap_entry = 3'd3;
        expect_rt(64'h30, 1'b1, 128'h300, 1'b0, 1'b0);
        expect_rt(64'h31, 1'b1, 128'h301, 1'b0, 1'b1);
        tick();
        clr_wb(); trap_valid = 1'b0;
        #1 chk("t3_rt_valid", 128'(rt_valid), 128'(4'b0011));
        chk("t3_rt_trap", 128'(rt_trap), 128'(4'b0010));
        chk("t3_dp_ready", 128'(dp_ready), 128'(2'b00));
        chk("t3_occ", 128'(occupancy), 128'(4));
        rt_ready = 4'b1111;
        tick();
        chk("t3_flush_occ", 128'(occupancy), 128'(0));
        chk("t3_flush_index", 128'(dp_index), 128'(0));
        chk("t3_flush_rt", 128'(rt_valid), 128'(0));
        chk("t3_flush_ready", 128'(dp_ready), 128'(2'b11));

        // Fill all eight entries, then free one and wrap the write pointer
        dp_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            dp_info = {64'h41 + 64'(2*k), 64'h40 + 64'(2*k)};
            tick();
        end
        #1 chk("t2_full_occ", 128'(occupancy), 128'(8));
        chk("t2_full_ready", 128'(dp_ready), 128'(2'b00));
        chk("t2_full_index", 128'(dp_index), 128'(0));
        dp_valid = '0;
        set_wb(8, 0, 1'b0, 128'h400, 1'b0);
        expect_rt(64'h40, 1'b0, 128'h400, 1'b0, 1'b0);
        tick();
        clr_wb();
        #1 chk("t2_rt_one", 128'(rt_valid), 128'(4'b0001));
        tick();
        chk("t2_occ7", 128'(occupancy), 128'(7));
        chk("t2_ready01", 128'(dp_ready), 128'(2'b01));
        chk("t2_index_wrap", 128'(dp_index), 128'(0));
        dp_valid = 2'b01; dp_info = {64'h0, 64'h48};
        tick();
        dp_valid = '0;
        #1 chk("t2_occ8", 128'(occupancy), 128'(8));
        chk("t2_index1", 128'(dp_index), 128'(1));

        // Four retireable slots, ready 1011: only the leading two are taken
        rt_ready = 4'b1011;
        for (int k = 0; k < 4; k++) set_wb(k, 1 + k, 1'b1, 128'h401 + 128'(k), k[0]);
        expect_rt(64'h41, 1'b1, 128'h401, 1'b0, 1'b0);
        expect_rt(64'h42, 1'b1, 128'h402, 1'b1, 1'b0);
        expect_rt(64'h43, 1'b1, 128'h403, 1'b0, 1'b0);
        expect_rt(64'h44, 1'b1, 128'h404, 1'b1, 1'b0);
        tick();
        clr_wb();
        #1 chk("t4_rt_valid", 128'(rt_valid), 128'(4'b1111));
        chk("t4_rt_info0", 128'(rt_info[63:0]), 128'(64'h41));
        tick();
        rt_ready = '0;
        #1 chk("t4_occ6", 128'(occupancy), 128'(6));
        chk("t4_rt_valid2", 128'(rt_valid), 128'(4'b0011));
        chk("t4_rt_info_next", 128'(rt_info[63:0]), 128'(64'h43));

        // Non-prefix dispatch request is ignored
        dp_valid = 2'b10; dp_info = {64'h77, 64'h66};
        #1 chk("t5_ready", 128'(dp_ready), 128'(2'b11));
        tick();
        dp_valid = '0;
        #1 chk("t5_occ", 128'(occupancy), 128'(6));
        chk("t5_index", 128'(dp_index), 128'(1));
        rt_ready = 4'b1111;
        tick();
        chk("t5_occ4", 128'(occupancy), 128'(4));

        // Asynchronous reset with five entries in flight
        dp_valid = 2'b01; dp_info = {64'h0, 64'h49};
        tick();
        dp_valid = '0;
        #1 chk("t6_occ5", 128'(occupancy), 128'(5));
        chk("t6_index2", 128'(dp_index), 128'(2));
        #1 rst_n = 1'b0;
        #1 chk("t6_rst_occ", 128'(occupancy), 128'(0));
        chk("t6_rst_rt", 128'(rt_valid), 128'(0));
        chk("t6_rst_index", 128'(dp_index), 128'(0));
        chk("t6_rst_ready", 128'(dp_ready), 128'(0));
        chk("t6_rst_trap_ready", 128'(trap_ready), 128'(1));
        tick();
        rst_n = 1'b1;
        dp_valid = 2'b01; dp_info = {64'h0, 64'h50};
        #1 chk("t6_post_ready", 128'(dp_ready), 128'(2'b11));
        chk("t6_post_index", 128'(dp_index), 128'(0));
        tick();
        dp_valid = '0;
        set_wb(8, 0, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, 1'b1);
        expect_rt(64'h50, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, 1'b1, 1'b0);
        #1 chk("t6_post_occ", 128'(occupancy), 128'(1));
        chk("t6_post_index1", 128'(dp_index), 128'(1));
        tick();
        clr_wb();
        #1 chk("t6_rt_one", 128'(rt_valid), 128'(4'b0001));
        tick();
        chk("t6_final_occ", 128'(occupancy), 128'(0));
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
